// File: rtl/fetch_pc.sv
// Instruction fetch sequencer: PC register, single-outstanding imem read, decode handshake.
// Optional return-address stack compiled in with FETCH_RAS_EN.
module fetch_pc #(
   parameter logic [7:0]  RESET_PC  = 8'h00,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  next_pc,
   output logic [7:0]  pc,
   output logic        imem_req,
   output logic [7:0]  imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   output logic [15:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        flush,
   input  logic [7:0]  flush_pc,
   input  logic        call,
   input  logic        ret,
   output logic        ras_underflow
);

   typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

   state_e      state_q, state_d;
   logic [7:0]  pc_q, pc_d;
   logic [15:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        underflow_q, underflow_d;

`ifdef FETCH_RAS_EN
   localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
   localparam logic [PW-1:0] LAST_IDX = PW'(RAS_DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

   logic [7:0]    ras_mem [RAS_DEPTH];
   logic [PW-1:0] wr_ptr_q, top_idx, next_wr;
   logic [CW-1:0] cnt_q;
   logic          push, pop;

   // wr_ptr points at the slot the next push writes; top of stack sits just below it
   assign top_idx = (wr_ptr_q == '0) ? LAST_IDX : wr_ptr_q - 1'b1;
   assign next_wr = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
`else
   logic unused_ras;
   assign unused_ras = call ^ ret ^ (RAS_DEPTH == 0);
`endif

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      valid_d     = valid_q;
      underflow_d = 1'b0;
`ifdef FETCH_RAS_EN
      push        = 1'b0;
      pop         = 1'b0;
`endif
      if (flush) begin
         state_d = StReq;
         pc_d    = flush_pc;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
               if (imem_ack) begin
                  instr_d = imem_rdata;
                  valid_d = 1'b1;
                  state_d = StHold;
               end
            end
            StHold: begin
               if (valid_q && instr_ready) begin
                  valid_d = 1'b0;
                  state_d = StReq;
                  pc_d    = next_pc;
`ifdef FETCH_RAS_EN
                  // ret wins over call when both are set
                  if (ret) begin
                     if (cnt_q != '0) begin
                        pc_d = ras_mem[top_idx];
                        pop  = 1'b1;
                     end else begin
                        underflow_d = 1'b1;
                     end
                  end else if (call) begin
                     push = 1'b1;
                  end
`endif
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         pc_q        <= RESET_PC;
         instr_q     <= 16'h0000;
         valid_q     <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         valid_q     <= valid_d;
         underflow_q <= underflow_d;
      end
   end

`ifdef FETCH_RAS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (push) begin
         wr_ptr_q <= next_wr;
         if (cnt_q != FULL_CNT) cnt_q <= cnt_q + 1'b1;
      end else if (pop) begin
         wr_ptr_q <= top_idx;
         cnt_q    <= cnt_q - 1'b1;
      end
   end

   // Storage needs no reset: validity is tracked by cnt_q
   always_ff @(posedge clk) begin
      if (rst_n && push) ras_mem[wr_ptr_q] <= pc_q + 8'd1;
   end
`endif

   assign pc            = pc_q;
   assign imem_addr     = pc_q;
   assign imem_req      = (state_q == StReq);
   assign instr         = instr_q;
   assign instr_valid   = valid_q;
   assign ras_underflow = underflow_q;

endmodule

// File: tb/tb_fetch_pc.sv
// Directed self-checking bench for fetch_pc; RAS checks adapt to FETCH_RAS_EN.
module tb_fetch_pc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  next_pc, pc, imem_addr, flush_pc;
   logic        imem_req, imem_ack, instr_valid, instr_ready, flush, call, ret, ras_underflow;
   logic [15:0] imem_rdata, instr;

   int errors = 0;
   int checks = 0;

   fetch_pc dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .next_pc       (next_pc),
      .pc            (pc),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .flush         (flush),
      .flush_pc      (flush_pc),
      .call          (call),
      .ret           (ret),
      .ras_underflow (ras_underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // From HOLD: accept with given call/ret, check new pc, then refetch into HOLD
   task automatic accept(input logic [7:0] np, input logic c, input logic r,
                         input logic [7:0] exp_pc, input logic exp_uf, input string tag);
      next_pc = np; call = c; ret = r; instr_ready = 1'b1; imem_ack = 1'b1;
      tick();
      check({tag, "_pc"}, pc, exp_pc);
      check({tag, "_uf"}, ras_underflow, exp_uf);
      call = 1'b0; ret = 1'b0;
      tick();
      check({tag, "_uf_clr"}, ras_underflow, 1'b0);
   endtask

   initial begin
      logic [7:0] base;
      rst_n = 1'b0; next_pc = 8'h00; imem_ack = 1'b1; imem_rdata = 16'hA5A5;
      instr_ready = 1'b1; flush = 1'b0; flush_pc = 8'h00; call = 1'b0; ret = 1'b0;
      tick(); tick();
      check("rst_pc", pc, 8'h00);
      check("rst_req", imem_req, 1'b0);
      check("rst_valid", instr_valid, 1'b0);
      check("rst_instr", instr, 16'h0000);
      check("rst_uf", ras_underflow, 1'b0);

      // Zero-wait streaming: one instruction per two cycles
      rst_n = 1'b1; next_pc = 8'h01;
      tick();
      check("zw_req0", imem_req, 1'b1);
      check("zw_addr0", imem_addr, 8'h00);
      tick();
      check("zw_valid0", instr_valid, 1'b1);
      check("zw_instr0", instr, 16'hA5A5);
      check("zw_hold_req", imem_req, 1'b0);
      tick();
      check("zw_req1", imem_req, 1'b1);
      check("zw_addr1", imem_addr, 8'h01);
      check("zw_valid_clr", instr_valid, 1'b0);
      tick();
      check("zw_valid1", instr_valid, 1'b1);

      // Delayed ack: request and address held
      next_pc = 8'h10; imem_ack = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         check("dly_req", imem_req, 1'b1);
         check("dly_addr", imem_addr, 8'h10);
         check("dly_valid", instr_valid, 1'b0);
         if (i == 2) begin
            imem_ack = 1'b1; imem_rdata = 16'h1234;
         end
         tick();
      end
      check("dly_valid_set", instr_valid, 1'b1);
      check("dly_instr", instr, 16'h1234);

      // Decode stall: stray ack with new data must not disturb HOLD
      instr_ready = 1'b0; imem_rdata = 16'hFFFF;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_instr", instr, 16'h1234);
         check("stall_pc", pc, 8'h10);
         check("stall_req", imem_req, 1'b0);
         check("stall_valid", instr_valid, 1'b1);
      end
      instr_ready = 1'b1; next_pc = 8'h20; imem_ack = 1'b0;
      tick();
      check("stall_rel_pc", pc, 8'h20);

      // Flush coinciding with ack drops the data
      imem_ack = 1'b1; imem_rdata = 16'hBEEF; flush = 1'b1; flush_pc = 8'h40;
      tick();
      flush = 1'b0;
      check("fl_ack_valid", instr_valid, 1'b0);
      check("fl_ack_instr", instr, 16'h1234);
      check("fl_ack_addr", imem_addr, 8'h40);
      check("fl_ack_req", imem_req, 1'b1);
      imem_rdata = 16'h5555;
      tick();
      check("fl_refetch", instr, 16'h5555);

      // Flush coinciding with acceptance ignores next_pc and call
      flush = 1'b1; flush_pc = 8'h33; next_pc = 8'h77; call = 1'b1;
      tick();
      flush = 1'b0; call = 1'b0;
      check("fl_acc_pc", pc, 8'h33);
      check("fl_acc_valid", instr_valid, 1'b0);
      tick();

      // Call at pc=FF pushes wrapped 00
      next_pc = 8'hFF;
      tick(); tick();
      check("wrap_pc", pc, 8'hFF);
      accept(8'h80, 1'b1, 1'b0, 8'h80, 1'b0, "call_ff");
`ifdef FETCH_RAS_EN
      accept(8'h55, 1'b0, 1'b1, 8'h00, 1'b0, "ret_wrap");
      base = 8'h00;
`else
      accept(8'h55, 1'b0, 1'b1, 8'h55, 1'b0, "ret_wrap");
      base = 8'h55;
`endif

      // Five calls overflow a depth-4 stack; the oldest return address is lost
      accept(8'h10, 1'b1, 1'b0, 8'h10, 1'b0, "call1");
      accept(8'h20, 1'b1, 1'b0, 8'h20, 1'b0, "call2");
      accept(8'h30, 1'b1, 1'b0, 8'h30, 1'b0, "call3");
      accept(8'h40, 1'b1, 1'b0, 8'h40, 1'b0, "call4");
      accept(8'h50, 1'b1, 1'b0, 8'h50, 1'b0, "call5");
`ifdef FETCH_RAS_EN
      accept(8'hE0, 1'b0, 1'b1, 8'h41, 1'b0, "ret1");
      accept(8'hE0, 1'b0, 1'b1, 8'h31, 1'b0, "ret2");
      accept(8'hE0, 1'b0, 1'b1, 8'h21, 1'b0, "ret3");
      accept(8'hE0, 1'b0, 1'b1, 8'h11, 1'b0, "ret4");
      accept(8'hE0, 1'b0, 1'b1, 8'hE0, 1'b1, "ret5_under");
      // call with ret behaves as ret; empty again so underflows
      accept(8'hE4, 1'b1, 1'b1, 8'hE4, 1'b1, "callret");
      accept(8'hE8, 1'b0, 1'b1, 8'hE8, 1'b1, "callret_nopush");
`else
      accept(8'hE0, 1'b0, 1'b1, 8'hE0, 1'b0, "ret1");
      accept(8'hE1, 1'b0, 1'b1, 8'hE1, 1'b0, "ret2");
      accept(8'hE4, 1'b1, 1'b1, 8'hE4, 1'b0, "callret");
`endif
      check("base_used", base + 8'd1, (base == 8'h00) ? 8'h01 : 8'h56);

      // Reset mid-request abandons it; late ack ignored
      next_pc = 8'h90; imem_ack = 1'b0;
      tick();
      check("mid_req", imem_req, 1'b1);
      rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 16'hDEAD;
      tick();
      check("mid_rst_pc", pc, 8'h00);
      check("mid_rst_req", imem_req, 1'b0);
      check("mid_rst_valid", instr_valid, 1'b0);
      check("mid_rst_instr", instr, 16'h0000);
      rst_n = 1'b1;
      tick();
      check("mid_idle_ack_ignored", instr_valid, 1'b0);
      check("mid_rst_req_again", imem_req, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_pc.md
FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00: PC value loaded by reset.
REQ-002 SHALL have parameter RAS_DEPTH, default 4: return-address stack entries, used only with FETCH_RAS_EN.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port next_pc, input, 8: target from next-PC logic, valid while instr_valid=1.
REQ-006 SHALL have port pc, output, 8: current PC.
REQ-007 SHALL have port imem_req, output, 1: instruction memory read request.
REQ-008 SHALL have port imem_addr, output, 8: fetch address, equal to pc.
REQ-009 SHALL have port imem_ack, input, 1: memory read complete; imem_rdata is valid in the same cycle.
REQ-010 SHALL have port imem_rdata, input, 16: fetched instruction word.
REQ-011 SHALL have port instr, output, 16: held instruction word.
REQ-012 SHALL have port instr_valid, output, 1: instr is valid for decode.
REQ-013 SHALL have port instr_ready, input, 1: decode accepts instr this cycle.
REQ-014 SHALL have port flush, input, 1: redirect request; has priority over all other inputs.
REQ-015 SHALL have port flush_pc, input, 8: redirect target.
REQ-016 SHALL have port call, input, 1: accepted instruction is a call; push return address.
REQ-017 SHALL have port ret, input, 1: accepted instruction is a return; pop PC.
REQ-018 SHALL have port ras_underflow, output, 1: one-cycle pulse when ret is accepted while the stack is empty.

Function
REQ-019 SHALL implement FSM states IDLE, REQ, HOLD.
REQ-020 IDLE SHALL drive imem_req=0 and move to REQ on the next cycle.
REQ-021 REQ SHALL drive imem_req=1 and imem_addr=pc; on imem_ack it SHALL capture imem_rdata into instr, set instr_valid=1 and move to HOLD.
REQ-022 In REQ without imem_ack, the FSM SHALL stay in REQ with pc unchanged.
REQ-023 HOLD SHALL drive imem_req=0 and instr_valid=1, with instr stable.
REQ-024 In HOLD, instr_valid&&instr_ready SHALL clear instr_valid, load pc<=next_pc and move to REQ; the next request issues one cycle after acceptance.
REQ-025 Minimum throughput SHALL be one instruction per 2 cycles when imem_ack is zero-wait.
REQ-026 flush=1 in any state SHALL set pc<=flush_pc, clear instr_valid and move to REQ.
REQ-027 A flush coinciding with imem_ack SHALL discard the returned data.
REQ-028 A flush coinciding with acceptance SHALL take flush_pc and ignore next_pc, call and ret.
REQ-029 All PC arithmetic SHALL be modulo 256; 8'hFF+1 SHALL wrap to 8'h00.

Reset
REQ-030 rst_n=0 at a clk edge SHALL force state=IDLE, pc=RESET_PC, instr=16'h0000, instr_valid=0, imem_req=0, ras_underflow=0, and an empty stack.
REQ-031 Reset mid-transaction SHALL abandon the outstanding request; a late imem_ack SHALL be ignored outside REQ.

Configuration
REQ-032 Macro FETCH_RAS_EN SHALL compile the return-address stack in or out.
REQ-033 Defined, on acceptance with call=1: SHALL push (pc+1) mod 256 and load pc<=next_pc.
REQ-034 Defined, on acceptance with ret=1: SHALL load pc<=top-of-stack and pop, ignoring next_pc.
REQ-035 Defined, push when full: SHALL overwrite the oldest entry (circular); depth stays RAS_DEPTH.
REQ-036 Defined, ret when empty: SHALL load pc<=next_pc and pulse ras_underflow for one cycle.
REQ-037 Defined, call and ret both set: SHALL treat as ret.
REQ-038 Undefined: call and ret SHALL be ignored, ras_underflow SHALL be tied to 0, and all ports SHALL remain present.

Verification
REQ-039 Reset, then zero-wait ack with rdata=16'hA5A5, next_pc=8'h01 and ready=1 -> imem_addr 00 then 01; instr=A5A5; one instruction per 2 cycles.
REQ-040 Ack delayed 3 cycles -> imem_req held 3 cycles with addr stable; then instr_valid=1.
REQ-041 instr_ready held low 5 cycles in HOLD -> instr and pc unchanged; no new imem_req.
REQ-042 flush with flush_pc=8'h40 in the same cycle as imem_ack -> data dropped; next imem_addr=40.
REQ-043 With pc=8'hFF and call=1 -> 8'h00 pushed; a later ret -> pc=00.
REQ-044 With FETCH_RAS_EN: 5 calls then 5 rets with depth 4 -> first 4 rets return the most recent addresses; 5th ret pulses ras_underflow and takes next_pc.
